// File: rtl/bcd_serial_addsub_if.sv
// Handshake and result bus for the serial 4-digit BCD adder/subtractor.
// The slave side is the datapath; the master side drives digits and consumes results.
interface bcd_serial_addsub_if;
  logic        start;
  logic        sub;
  logic [3:0]  a_dig;
  logic [3:0]  b_dig;
  logic        dig_valid;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        neg;
  logic        err;

  modport slave (
    input  start, sub, a_dig, b_dig, dig_valid,
    output busy, done, result, cout, neg, err
  );

  modport master (
    output start, sub, a_dig, b_dig, dig_valid,
    input  busy, done, result, cout, neg, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial 4-digit BCD adder/subtractor, LSD first. Subtraction expects B already
// 9's-complemented upstream; the +1 enters through the initial carry.
module bcd_serial_addsub (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_addsub_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [1:0]  cnt_q,    cnt_d;
  logic        carry_q,  carry_d;
  logic        sub_q,    sub_d;
  logic [15:0] result_q, result_d;
  logic        cout_q,   cout_d;
  logic        neg_q,    neg_d;
  logic        err_q,    err_d;

  logic [4:0]  dig_sum;
  logic [4:0]  dig_adj;

  // Decimal adjust of a raw 5-bit digit sum: returns {carry, digit}.
  // Out-of-range inputs still wrap to the low 4 bits of s-10.
  function automatic logic [4:0] bcd_digit_adj(input logic [4:0] sum);
    logic [4:0] wrapped;
    wrapped = sum - 5'd10;
    if (sum > 5'd9) return {1'b1, wrapped[3:0]};
    else            return {1'b0, sum[3:0]};
  endfunction

  assign dig_sum = {1'b0, bus.a_dig} + {1'b0, bus.b_dig} + {4'b0000, carry_q};
  assign dig_adj = bcd_digit_adj(dig_sum);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    result_d = result_q;
    cout_d   = cout_q;
    neg_d    = neg_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          carry_d  = bus.sub;
          sub_d    = bus.sub;
          cnt_d    = 2'd0;
          result_d = 16'h0000;
          cout_d   = 1'b0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
        end
      end

      S_RUN: begin
        if (bus.dig_valid) begin
          case (cnt_q)
            2'd0:    result_d[3:0]   = dig_adj[3:0];
            2'd1:    result_d[7:4]   = dig_adj[3:0];
            2'd2:    result_d[11:8]  = dig_adj[3:0];
            default: result_d[15:12] = dig_adj[3:0];
          endcase
          carry_d = dig_adj[4];
          cnt_d   = cnt_q + 2'd1;
          if ((bus.a_dig > 4'd9) || (bus.b_dig > 4'd9)) err_d = 1'b1;
          if (cnt_q == 2'd3) begin
            state_d = S_DONE;
            cout_d  = dig_adj[4];
            neg_d   = sub_q & ~dig_adj[4];
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule
